// File: rtl/data_bus_responder.sv
// Responder end of the core data bus: word RAM, compare-match timer and GPIO
// registers behind a single address decoder, plus the timer interrupt to the core.
module data_bus_responder #(
   parameter int RAM_WORDS = 1024,
   parameter int GPIO_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_ren,
   input  logic              mem_wen,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_dout,
   output logic [31:0]       mem_din,
   output logic              ir_out,
   output logic [GPIO_W-1:0] gpio_out,
   input  logic [GPIO_W-1:0] gpio_in
);
   localparam int AW = $clog2(RAM_WORDS);

   localparam logic [5:0] OFF_TCNT     = 6'h00;
   localparam logic [5:0] OFF_TCMP     = 6'h01;
   localparam logic [5:0] OFF_CTRL     = 6'h02;
   localparam logic [5:0] OFF_STATUS   = 6'h03;
   localparam logic [5:0] OFF_GPIO_OUT = 6'h04;
   localparam logic [5:0] OFF_GPIO_IN  = 6'h05;

   // Bus handshake: single-cycle, no ready. Read data is valid combinationally in the
   // cycle mem_ren is high; a write with mem_wen high commits on that cycle's rising edge.

   logic              ram_hit;
   logic              mmio_hit;
   logic [5:0]        mmio_off;
   logic [AW-1:0]     ram_idx;
   logic              we_tcnt, we_tcmp, we_ctrl, we_status, we_gpio;
   logic              bus_err_set;
   logic              timer_match;
   logic              unused_addr_lsbs;

   logic [31:0]       ram [RAM_WORDS];
   logic [31:0]       tcnt, tcnt_nxt;
   logic [31:0]       tcmp;
   logic [2:0]        ctrl;
   logic              pending, pending_nxt;
   logic              bus_err, bus_err_nxt;
   logic [GPIO_W-1:0] gpio_s1, gpio_s2;
   logic [31:0]       gpio_out_rd, gpio_in_rd;

   // Address decode; byte-lane bits are ignored, all accesses are whole words.
   assign ram_hit  = (mem_addr[31:28] == 4'h0) && (mem_addr[31:2] < 30'(RAM_WORDS));
   assign ram_idx  = mem_addr[AW+1:2];
   assign mmio_off = mem_addr[7:2];
   assign mmio_hit = (mem_addr[31:8] == 24'hF00000) && (mmio_off <= OFF_GPIO_IN);

   assign unused_addr_lsbs = ^mem_addr[1:0];

   assign we_tcnt   = mem_wen && mmio_hit && (mmio_off == OFF_TCNT);
   assign we_tcmp   = mem_wen && mmio_hit && (mmio_off == OFF_TCMP);
   assign we_ctrl   = mem_wen && mmio_hit && (mmio_off == OFF_CTRL);
   assign we_status = mem_wen && mmio_hit && (mmio_off == OFF_STATUS);
   assign we_gpio   = mem_wen && mmio_hit && (mmio_off == OFF_GPIO_OUT);

   assign bus_err_set = (mem_ren || mem_wen) && !ram_hit && !mmio_hit;
   assign timer_match = ctrl[0] && (tcnt == tcmp);

   // Timer and status next-state: core writes beat the counter, set events beat W1C.
   always_comb begin
      tcnt_nxt    = tcnt;
      pending_nxt = pending;
      bus_err_nxt = bus_err;
      if (ctrl[0]) begin
         if (timer_match && ctrl[2]) begin
            tcnt_nxt = '0;
         end else begin
            tcnt_nxt = tcnt + 32'd1;
         end
      end
      if (we_tcnt) begin
         tcnt_nxt = mem_dout;
      end
      if (we_status && mem_dout[0]) begin
         pending_nxt = 1'b0;
      end
      if (we_status && mem_dout[1]) begin
         bus_err_nxt = 1'b0;
      end
      if (timer_match) begin
         pending_nxt = 1'b1;
      end
      if (bus_err_set) begin
         bus_err_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt     <= '0;
         tcmp     <= 32'hFFFF_FFFF;
         ctrl     <= '0;
         pending  <= 1'b0;
         bus_err  <= 1'b0;
         gpio_out <= '0;
         gpio_s1  <= '0;
         gpio_s2  <= '0;
      end else begin
         tcnt    <= tcnt_nxt;
         pending <= pending_nxt;
         bus_err <= bus_err_nxt;
         if (we_tcmp) begin
            tcmp <= mem_dout;
         end
         if (we_ctrl) begin
            ctrl <= mem_dout[2:0];
         end
         if (we_gpio) begin
            gpio_out <= mem_dout[GPIO_W-1:0];
         end
         gpio_s1 <= gpio_in;
         gpio_s2 <= gpio_s1;
      end
   end

   // RAM has no reset, so a write presented during reset still lands.
   always_ff @(posedge clk) begin
      if (mem_wen && ram_hit) begin
         ram[ram_idx] <= mem_dout;
      end
   end

   assign ir_out = pending && ctrl[1];

   always_comb begin
      gpio_out_rd               = '0;
      gpio_out_rd[GPIO_W-1:0]   = gpio_out;
      gpio_in_rd                = '0;
      gpio_in_rd[GPIO_W-1:0]    = gpio_s2;
   end

   // Read mux shows pre-edge state, so a same-cycle write is not visible yet.
   always_comb begin
      mem_din = '0;
      if (mem_ren) begin
         if (ram_hit) begin
            mem_din = ram[ram_idx];
         end else if (mmio_hit) begin
            case (mmio_off)
               OFF_TCNT:     mem_din = tcnt;
               OFF_TCMP:     mem_din = tcmp;
               OFF_CTRL:     mem_din = {29'd0, ctrl};
               OFF_STATUS:   mem_din = {30'd0, bus_err, pending};
               OFF_GPIO_OUT: mem_din = gpio_out_rd;
               OFF_GPIO_IN:  mem_din = gpio_in_rd;
               default:      mem_din = '0;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed scenarios with fixed expectations, then
// randomized traffic checked against a register-map level model of the responder.
module tb_data_bus_responder;
   localparam int RAM_WORDS = 1024;
   localparam int GPIO_W    = 16;

   localparam logic [31:0] A_TCNT   = 32'hF000_0000;
   localparam logic [31:0] A_TCMP   = 32'hF000_0004;
   localparam logic [31:0] A_CTRL   = 32'hF000_0008;
   localparam logic [31:0] A_STATUS = 32'hF000_000C;
   localparam logic [31:0] A_GPO    = 32'hF000_0010;
   localparam logic [31:0] A_GPI    = 32'hF000_0014;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_ren;
   logic              mem_wen;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_dout;
   logic [31:0]       mem_din;
   logic              ir_out;
   logic [GPIO_W-1:0] gpio_out;
   logic [GPIO_W-1:0] gpio_in;

   int n_checks = 0;
   int n_bad    = 0;

   data_bus_responder #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_ren  (mem_ren),
      .mem_wen  (mem_wen),
      .mem_addr (mem_addr),
      .mem_dout (mem_dout),
      .mem_din  (mem_din),
      .ir_out   (ir_out),
      .gpio_out (gpio_out),
      .gpio_in  (gpio_in)
   );

   // ---------------- clock ----------------
   always #50 clk = ~clk;

   // ---------------- reference model (register map view) ----------------
   logic [31:0]       m_tcnt, m_tcmp;
   logic [2:0]        m_ctrl;
   logic              m_pend, m_berr;
   logic [GPIO_W-1:0] m_gpo;
   logic [GPIO_W-1:0] m_gpi_seen [2];
   logic [31:0]       m_ram [int unsigned];

   function automatic logic is_ram(input logic [31:0] a);
      return (a[31:28] == 4'h0) && (int'(a[31:2]) < RAM_WORDS);
   endfunction

   function automatic logic is_mmio(input logic [31:0] a);
      return (a[31:8] == 24'hF00000) && ({a[7:2], 2'b00} <= 8'h14);
   endfunction

   function automatic logic read_known(input logic ren, input logic [31:0] a);
      return !ren || !is_ram(a) || m_ram.exists(int'(a[31:2]));
   endfunction

   function automatic logic [31:0] model_read(input logic ren, input logic [31:0] a);
      logic [31:0] v;
      v = '0;
      if (ren && is_ram(a)) begin
         v = m_ram[int'(a[31:2])];
      end else if (ren && is_mmio(a)) begin
         case ({a[7:2], 2'b00})
            8'h00: v = m_tcnt;
            8'h04: v = m_tcmp;
            8'h08: v[2:0] = m_ctrl;
            8'h0C: v[1:0] = {m_berr, m_pend};
            8'h10: v[GPIO_W-1:0] = m_gpo;
            8'h14: v[GPIO_W-1:0] = m_gpi_seen[1];
            default: v = '0;
         endcase
      end
      return v;
   endfunction

   always @(posedge clk) begin : model_step
      logic [31:0] nt;
      logic        np, ne, we;
      logic [7:0]  off;
      if (mem_wen && is_ram(mem_addr)) m_ram[int'(mem_addr[31:2])] = mem_dout;
      if (rst) begin
         m_tcnt = '0; m_tcmp = 32'hFFFF_FFFF; m_ctrl = '0;
         m_pend = 1'b0; m_berr = 1'b0; m_gpo = '0;
         m_gpi_seen[0] = '0; m_gpi_seen[1] = '0;
      end else begin
         nt = m_tcnt; np = m_pend; ne = m_berr;
         off = {mem_addr[7:2], 2'b00};
         we = mem_wen && is_mmio(mem_addr);
         if (we && off == 8'h0C && mem_dout[0]) np = 1'b0;
         if (we && off == 8'h0C && mem_dout[1]) ne = 1'b0;
         if (m_ctrl[0]) begin
            if (m_tcnt == m_tcmp) begin
               np = 1'b1;
               nt = m_ctrl[2] ? 32'd0 : m_tcnt + 32'd1;
            end else begin
               nt = m_tcnt + 32'd1;
            end
         end
         if ((mem_ren || mem_wen) && !is_ram(mem_addr) && !is_mmio(mem_addr)) ne = 1'b1;
         if (we && off == 8'h00) nt = mem_dout;
         if (we && off == 8'h04) m_tcmp = mem_dout;
         if (we && off == 8'h08) m_ctrl = mem_dout[2:0];
         if (we && off == 8'h10) m_gpo = mem_dout[GPIO_W-1:0];
         m_tcnt = nt; m_pend = np; m_berr = ne;
         m_gpi_seen[1] = m_gpi_seen[0];
         m_gpi_seen[0] = gpio_in;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_ren = 1'b0; mem_wen = 1'b1; mem_addr = a; mem_dout = d;
      tick();
      mem_wen = 1'b0;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = a;
      #1;
      d = mem_din;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      peek(A_TCNT, d);   n_checks++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_tcnt got=%h want=%h", d, 32'h0); end
      peek(A_TCMP, d);   n_checks++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_tcmp got=%h want=%h", d, 32'hFFFF_FFFF); end
      peek(A_CTRL, d);   n_checks++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl got=%h want=0", d); end
      peek(A_STATUS, d); n_checks++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status got=%h want=0", d); end
      peek(A_GPO, d);    n_checks++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_gpo_reg got=%h want=0", d); end
      n_checks++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL reset_ir got=%b want=0", ir_out); end
      n_checks++; if (gpio_out !== '0) begin n_bad++; $display("FAIL reset_gpio_out got=%h want=0", gpio_out); end
   endtask

   task automatic test_ram();
      logic [31:0] d;
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      peek(32'h0000_0010, d); n_checks++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_rd got=%h want=deadbeef", d); end
      peek(32'h0000_0013, d); n_checks++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_rd_lsb got=%h want=deadbeef", d); end
      mem_ren = 1'b0; #1;
      n_checks++; if (mem_din !== 32'h0) begin n_bad++; $display("FAIL ram_no_ren got=%h want=0", mem_din); end
      wr(32'h0000_0FFC, 32'hA5A5_5A5A);
      peek(32'h0000_0FFC, d); n_checks++; if (d !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL ram_top got=%h want=a5a55a5a", d); end
   endtask

   task automatic test_timer_irq();
      logic [31:0] d;
      wr(A_TCMP, 32'd5); wr(A_TCNT, 32'd0); wr(A_CTRL, 32'd3);
      repeat (5) tick();
      peek(A_TCNT, d); n_checks++; if (d !== 32'd5) begin n_bad++; $display("FAIL irq_cnt5 got=%0d want=5", d); end
      n_checks++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL irq_early got=%b want=0", ir_out); end
      tick();
      n_checks++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL irq_set got=%b want=1", ir_out); end
      peek(A_TCNT, d);   n_checks++; if (d !== 32'd6) begin n_bad++; $display("FAIL irq_cnt6 got=%0d want=6", d); end
      peek(A_STATUS, d); n_checks++; if (d !== 32'd1) begin n_bad++; $display("FAIL irq_status got=%h want=1", d); end
      tick();
      peek(A_TCNT, d);   n_checks++; if (d !== 32'd7) begin n_bad++; $display("FAIL irq_cnt7 got=%0d want=7", d); end
      wr(A_STATUS, 32'd1);
      n_checks++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL irq_clear got=%b want=0", ir_out); end
      wr(A_CTRL, 32'd0);
   endtask

   task automatic test_autoreload();
      logic [31:0] d;
      wr(A_TCNT, 32'd0); wr(A_CTRL, 32'd7);
      repeat (5) tick();
      peek(A_TCNT, d); n_checks++; if (d !== 32'd5) begin n_bad++; $display("FAIL reload_cnt5 got=%0d want=5", d); end
      tick();
      peek(A_TCNT, d); n_checks++; if (d !== 32'd0) begin n_bad++; $display("FAIL reload_zero got=%0d want=0", d); end
      n_checks++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL reload_ir got=%b want=1", ir_out); end
      tick();
      peek(A_TCNT, d); n_checks++; if (d !== 32'd1) begin n_bad++; $display("FAIL reload_cnt1 got=%0d want=1", d); end
      wr(A_CTRL, 32'd0); wr(A_STATUS, 32'd1);
      peek(A_STATUS, d); n_checks++; if (d !== 32'd0) begin n_bad++; $display("FAIL reload_status got=%h want=0", d); end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      wr(A_TCNT, 32'd3); wr(A_CTRL, 32'd1);
      tick(); tick();
      peek(A_TCNT, d); n_checks++; if (d !== 32'd5) begin n_bad++; $display("FAIL prio_pre got=%0d want=5", d); end
      wr(A_STATUS, 32'd1);
      peek(A_STATUS, d); n_checks++; if (d !== 32'd1) begin n_bad++; $display("FAIL prio_set_wins got=%h want=1", d); end
      peek(A_TCNT, d);   n_checks++; if (d !== 32'd6) begin n_bad++; $display("FAIL prio_cnt6 got=%0d want=6", d); end
      wr(A_TCNT, 32'd100);
      peek(A_TCNT, d); n_checks++; if (d !== 32'd100) begin n_bad++; $display("FAIL prio_wr_wins got=%0d want=100", d); end
      tick();
      peek(A_TCNT, d); n_checks++; if (d !== 32'd101) begin n_bad++; $display("FAIL prio_after got=%0d want=101", d); end
      wr(A_CTRL, 32'd0); wr(A_STATUS, 32'd1);
      peek(A_STATUS, d); n_checks++; if (d !== 32'd0) begin n_bad++; $display("FAIL prio_clear got=%h want=0", d); end
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      wr(A_TCNT, 32'hFFFF_FFFF); wr(A_TCMP, 32'd0); wr(A_CTRL, 32'd1);
      tick();
      peek(A_TCNT, d);   n_checks++; if (d !== 32'd0) begin n_bad++; $display("FAIL wrap_cnt got=%h want=0", d); end
      peek(A_STATUS, d); n_checks++; if (d !== 32'd0) begin n_bad++; $display("FAIL wrap_nopend got=%h want=0", d); end
      tick();
      peek(A_STATUS, d); n_checks++; if (d !== 32'd1) begin n_bad++; $display("FAIL wrap_pend got=%h want=1", d); end
      n_checks++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL wrap_ir got=%b want=0", ir_out); end
      wr(A_CTRL, 32'd0); wr(A_STATUS, 32'd1);
   endtask

   task automatic test_unmapped();
      logic [31:0] d;
      wr(A_TCNT, 32'h55); wr(A_TCMP, 32'h66); wr(32'h0, 32'h1111_1111);
      mem_ren = 1'b1; mem_addr = 32'hF000_0040; #1;
      n_checks++; if (mem_din !== 32'h0) begin n_bad++; $display("FAIL unm_rd got=%h want=0", mem_din); end
      tick(); mem_ren = 1'b0;
      peek(A_STATUS, d); n_checks++; if (d !== 32'd2) begin n_bad++; $display("FAIL unm_berr got=%h want=2", d); end
      wr(A_STATUS, 32'd2);
      peek(A_STATUS, d); n_checks++; if (d !== 32'd0) begin n_bad++; $display("FAIL unm_w1c got=%h want=0", d); end
      wr(32'h8000_0000, 32'hFFFF_FFFF);
      peek(A_STATUS, d); n_checks++; if (d !== 32'd2) begin n_bad++; $display("FAIL unm_wr_berr got=%h want=2", d); end
      peek(A_TCNT, d);   n_checks++; if (d !== 32'h55) begin n_bad++; $display("FAIL unm_tcnt got=%h want=55", d); end
      peek(A_TCMP, d);   n_checks++; if (d !== 32'h66) begin n_bad++; $display("FAIL unm_tcmp got=%h want=66", d); end
      peek(A_CTRL, d);   n_checks++; if (d !== 32'h0) begin n_bad++; $display("FAIL unm_ctrl got=%h want=0", d); end
      peek(32'h0, d);    n_checks++; if (d !== 32'h1111_1111) begin n_bad++; $display("FAIL unm_ram0 got=%h want=11111111", d); end
      wr(A_STATUS, 32'd2);
      mem_ren = 1'b1; mem_addr = 32'h0000_1000; #1;
      n_checks++; if (mem_din !== 32'h0) begin n_bad++; $display("FAIL unm_ram_end got=%h want=0", mem_din); end
      tick(); mem_ren = 1'b0;
      peek(A_STATUS, d); n_checks++; if (d !== 32'd2) begin n_bad++; $display("FAIL unm_ram_end_berr got=%h want=2", d); end
      wr(A_STATUS, 32'd2);
   endtask

   task automatic test_gpio();
      logic [31:0] d;
      gpio_in = 16'h00A5;
      tick();
      peek(A_GPI, d); n_checks++; if (d !== 32'h0) begin n_bad++; $display("FAIL gpi_1cyc got=%h want=0", d); end
      tick();
      peek(A_GPI, d); n_checks++; if (d !== 32'h00A5) begin n_bad++; $display("FAIL gpi_2cyc got=%h want=a5", d); end
      wr(A_GPO, 32'hFFFF_1234);
      n_checks++; if (gpio_out !== 16'h1234) begin n_bad++; $display("FAIL gpo_pin got=%h want=1234", gpio_out); end
      peek(A_GPO, d); n_checks++; if (d !== 32'h0000_1234) begin n_bad++; $display("FAIL gpo_reg got=%h want=1234", d); end
      wr(A_GPI, 32'hFFFF_FFFF);
      peek(A_GPI, d);    n_checks++; if (d !== 32'h00A5) begin n_bad++; $display("FAIL gpi_ro got=%h want=a5", d); end
      peek(A_STATUS, d); n_checks++; if (d !== 32'h0) begin n_bad++; $display("FAIL gpi_ro_berr got=%h want=0", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      wr(A_TCMP, 32'd3); wr(A_TCNT, 32'd0); wr(A_CTRL, 32'd3);
      repeat (6) tick();
      n_checks++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL rmid_ir_pre got=%b want=1", ir_out); end
      rst = 1'b1;
      wr(A_GPO, 32'h0000_BEEF);
      wr(32'h0000_0020, 32'hCAFE_F00D);
      rst = 1'b0;
      n_checks++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL rmid_ir got=%b want=0", ir_out); end
      n_checks++; if (gpio_out !== '0) begin n_bad++; $display("FAIL rmid_gpo got=%h want=0", gpio_out); end
      peek(A_TCNT, d); n_checks++; if (d !== 32'h0) begin n_bad++; $display("FAIL rmid_tcnt got=%h want=0", d); end
      peek(A_TCMP, d); n_checks++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rmid_tcmp got=%h want=ffffffff", d); end
      peek(A_CTRL, d); n_checks++; if (d !== 32'h0) begin n_bad++; $display("FAIL rmid_ctrl got=%h want=0", d); end
      peek(A_GPI, d);  n_checks++; if (d !== 32'h0) begin n_bad++; $display("FAIL rmid_sync got=%h want=0", d); end
      peek(32'h10, d); n_checks++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rmid_ram10 got=%h want=deadbeef", d); end
      peek(32'h20, d); n_checks++; if (d !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL rmid_ram20 got=%h want=cafef00d", d); end
   endtask

   task automatic test_random();
      logic [31:0] a, d, exp;
      logic [31:0] unmapped [4];
      unmapped[0] = 32'hF000_0040; unmapped[1] = 32'h8000_0000;
      unmapped[2] = 32'h1000_0000; unmapped[3] = 32'h0000_1000;
      for (int i = 0; i < 800; i++) begin
         d = $urandom;
         case ($urandom_range(0, 9))
            0, 1, 2: a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            3:       a = 32'h0000_0FFC;
            4:       begin a = ($urandom_range(0, 1) == 0) ? A_TCNT : A_TCMP; d = $urandom_range(0, 24); end
            5:       begin a = ($urandom_range(0, 1) == 0) ? A_CTRL : A_STATUS; d = $urandom_range(0, 7); end
            6, 7:    a = 32'hF000_0000 | ($urandom_range(0, 6) << 2);
            default: a = unmapped[$urandom_range(0, 3)];
         endcase
         rst      = ($urandom_range(0, 99) == 0);
         mem_ren  = $urandom_range(0, 1) == 1;
         mem_wen  = $urandom_range(0, 3) == 0;
         mem_addr = a;
         mem_dout = d;
         if ($urandom_range(0, 9) == 0) gpio_in = GPIO_W'($urandom);
         #1;
         if (read_known(mem_ren, a)) begin
            exp = model_read(mem_ren, a);
            n_checks++;
            if (mem_din !== exp) begin n_bad++; $display("FAIL rnd_rd i=%0d addr=%h got=%h want=%h", i, a, mem_din, exp); end
         end
         n_checks++;
         if (ir_out !== (m_pend & m_ctrl[1])) begin n_bad++; $display("FAIL rnd_ir i=%0d got=%b want=%b", i, ir_out, m_pend & m_ctrl[1]); end
         n_checks++;
         if (gpio_out !== m_gpo) begin n_bad++; $display("FAIL rnd_gpo i=%0d got=%h want=%h", i, gpio_out, m_gpo); end
         tick();
      end
      rst = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0;
      mem_addr = '0; mem_dout = '0; gpio_in = '0;
      test_reset();
      test_ram();
      test_timer_irq();
      test_autoreload();
      test_priority();
      test_wrap();
      test_unmapped();
      test_gpio();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
